// File: rtl/fetch_queue.sv
// fetch_queue: circular-buffer FIFO decoupling instruction fetch from decode.
// Define FETCH_QUEUE_BYPASS_EN to let an entry pass straight through an empty queue in the same cycle.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [WIDTH-1:0]         enq_data,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [WIDTH-1:0]         deq_data,
    input  logic                     deq_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE     = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             enq_fire;
    logic             deq_fire;
    logic             do_write;
    logic             do_read;
    logic [WIDTH-1:0] head_data;

    // The extra wrap bit on each pointer makes full and empty distinguishable.
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == DEPTH_P);
    assign empty     = (count == '0);
    assign enq_ready = !full && !flush && !rst;
    assign head_data = mem[rd_ptr[AW-1:0]];

    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // An empty queue forwards the incoming entry; it is only stored if the consumer stalls.
    assign bypass    = empty && !flush && !rst && enq_valid;
    assign deq_valid = (!empty && !flush) || bypass;
    assign deq_data  = bypass    ? enq_data  :
                       deq_valid ? head_data : '0;
    assign do_write  = enq_fire && !(bypass && deq_ready);
    assign do_read   = deq_fire && !empty;
`else
    assign deq_valid = !empty && !flush;
    assign deq_data  = deq_valid ? head_data : '0;
    assign do_write  = enq_fire;
    assign do_read   = deq_fire;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + ONE;
            if (do_read)  rd_ptr <= rd_ptr + ONE;
        end
    end

    // Entry storage is deliberately not reset; deq_data masks stale contents.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= enq_data;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue-based reference model.
// Build with FETCH_QUEUE_BYPASS_EN defined to check the same-cycle bypass behaviour instead.
module tb_fetch_queue;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             enq_valid;
    logic [WIDTH-1:0] enq_data;
    logic             enq_ready;
    logic             deq_valid;
    logic [WIDTH-1:0] deq_data;
    logic             deq_ready;
    logic             flush;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q [$];
    logic             exp_full;
    logic             exp_empty;
    logic [CW-1:0]    exp_count;
    logic             exp_enq_ready;
    logic             exp_bypass;
    logic             exp_deq_valid;
    logic [WIDTH-1:0] exp_deq_data;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply inputs on the falling edge and derive the expected outputs from the model contents.
    task automatic drive(input logic ev, input logic [WIDTH-1:0] ed, input logic dr, input logic fl);
        @(negedge clk);
        enq_valid = ev;
        enq_data  = ed;
        deq_ready = dr;
        flush     = fl;
        #1;
        exp_count     = CW'(model_q.size());
        exp_full      = (model_q.size() == DEPTH);
        exp_empty     = (model_q.size() == 0);
        exp_enq_ready = !exp_full && !fl;
        exp_bypass    = BYPASS && exp_empty && !fl && ev;
        exp_deq_valid = (!exp_empty && !fl) || exp_bypass;
        if (!exp_deq_valid)  exp_deq_data = '0;
        else if (exp_empty)  exp_deq_data = ed;
        else                 exp_deq_data = model_q[0];
    endtask

    task automatic advance();
        logic enq_fire;
        logic deq_fire;
        enq_fire = enq_valid && exp_enq_ready;
        deq_fire = exp_deq_valid && deq_ready;
        @(posedge clk);
        if (flush) begin
            model_q.delete();
        end else if (!(exp_bypass && deq_fire)) begin
            if (deq_fire) void'(model_q.pop_front());
            if (enq_fire) model_q.push_back(enq_data);
        end
    endtask

    task automatic clear();
        drive(1'b0, '0, 1'b0, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        rst = 1'b1; enq_valid = 1'b1; enq_data = 64'h1234; deq_ready = 1'b1; flush = 1'b0;
        #2;
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_deq_valid: got %b expected 0", deq_valid); end
        checks++; if (deq_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_deq_data: got %h expected 0", deq_data); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_enq_ready: got %b expected 0", enq_ready); end
        @(posedge clk);
        #2 rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_enq_ready: got %b expected 1", enq_ready); end
        advance();
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33; vals[3] = 64'h44;
        clear();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], 1'b0, 1'b0);
            checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_enq_ready[%0d]: got %b expected 1", i, enq_ready); end
            advance();
        end
        drive(1'b1, 64'h99, 1'b0, 1'b0);
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_enq_ready_full: got %b expected 0", enq_ready); end
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", count); end
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (deq_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid[%0d]: got %b expected 1", i, deq_valid); end
            checks++; if (deq_data !== vals[i]) begin errors++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, deq_data, vals[i]); end
            advance();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_deq_valid: got %b expected 0", deq_valid); end
        advance();
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] got [$];
        logic [CW-1:0]    max_cnt;
        max_cnt = BYPASS ? 3'd0 : 3'd1;
        clear();
        for (int c = 0; c < 12; c++) begin
            drive(c < 10, 64'(c + 1), 1'b1, 1'b0);
            checks++; if (count > max_cnt) begin errors++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected at most %0d", c, count, max_cnt); end
            if (deq_valid === 1'b1) got.push_back(deq_data);
            advance();
        end
        checks++;
        if (got.size() != 10) begin
            errors++; $display("[TB] FAIL wrap_total: got %0d entries expected 10", got.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++; if (got[k] !== 64'(k + 1)) begin errors++; $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", k, got[k], 64'(k + 1)); end
            end
        end
    endtask

    task automatic test_flush();
        clear();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'hA1 + 64'(i), 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 64'h55, 1'b1, 1'b1);
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_enq_ready: got %b expected 0", enq_ready); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_deq_valid: got %b expected 0", deq_valid); end
        advance();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty: got %b expected 1", empty); end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (deq_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_leak[%0d]: deq_valid %b data %h expected nothing", i, deq_valid, deq_data); end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        clear();
        drive(1'b1, 64'h201, 1'b0, 1'b0); advance();
        drive(1'b1, 64'h202, 1'b0, 1'b0); advance();
        drive(1'b1, 64'h203, 1'b1, 1'b0);
        checks++; if (deq_data !== 64'h201) begin errors++; $display("[TB] FAIL b2b_data: got %h expected 201", deq_data); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_enq_ready: got %b expected 1", enq_ready); end
        advance();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", count); end
        advance();
        drive(1'b1, 64'h204, 1'b0, 1'b0); advance();
        drive(1'b1, 64'h205, 1'b0, 1'b0); advance();
        drive(1'b1, 64'h206, 1'b1, 1'b0);
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_enq_ready: got %b expected 0", enq_ready); end
        checks++; if (deq_data !== 64'h202) begin errors++; $display("[TB] FAIL full_deq_data: got %h expected 202", deq_data); end
        advance();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL full_reject_count: got %0d expected 3", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL full_reject_full: got %b expected 0", full); end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (deq_data !== 64'h203 + 64'(i)) begin errors++; $display("[TB] FAIL full_drain[%0d]: got %h expected %h", i, deq_data, 64'h203 + 64'(i)); end
            advance();
        end
    endtask

    task automatic test_async_reset();
        clear();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h301 + 64'(i), 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 64'h77, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        model_q.delete();
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_deq_valid: got %b expected 0", deq_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL async_count: got %0d expected 0", count); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("[TB] FAIL async_enq_ready: got %b expected 0", enq_ready); end
        checks++; if (deq_data !== 64'h0) begin errors++; $display("[TB] FAIL async_deq_data: got %h expected 0", deq_data); end
        @(posedge clk);
        #2 rst = 1'b0;
        drive(1'b1, 64'h88, 1'b0, 1'b0);
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_release_enq_ready: got %b expected 1", enq_ready); end
        advance();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (deq_data !== 64'h88) begin errors++; $display("[TB] FAIL async_first_entry: got %h expected 88", deq_data); end
        advance();
    endtask

    task automatic test_bypass();
        clear();
        drive(1'b1, 64'hABCD, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++; if (deq_valid !== 1'b1) begin errors++; $display("[TB] FAIL bypass_valid: got %b expected 1", deq_valid); end
        checks++; if (deq_data !== 64'hABCD) begin errors++; $display("[TB] FAIL bypass_data: got %h expected abcd", deq_data); end
`else
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("[TB] FAIL nobypass_valid: got %b expected 0", deq_valid); end
`endif
        advance();
        drive(1'b0, '0, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL bypass_count: got %0d expected 0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("[TB] FAIL bypass_next_valid: got %b expected 0", deq_valid); end
`else
        checks++; if (deq_valid !== 1'b1) begin errors++; $display("[TB] FAIL nobypass_next_valid: got %b expected 1", deq_valid); end
        checks++; if (deq_data !== 64'hABCD) begin errors++; $display("[TB] FAIL nobypass_next_data: got %h expected abcd", deq_data); end
`endif
        advance();
    endtask

    // Alternating phases of light and heavy draining push the queue through both full and empty.
    task automatic test_random();
        logic             ev;
        logic             dr;
        logic             fl;
        logic [WIDTH-1:0] ed;
        int               pct;
        clear();
        for (int i = 0; i < 400; i++) begin
            pct = ((i / 50) % 2 == 1) ? 80 : 25;
            ev  = ($urandom_range(0, 3) != 0);
            dr  = ($urandom_range(0, 99) < pct);
            fl  = ($urandom_range(0, 29) == 0);
            ed  = {$urandom, $urandom};
            drive(ev, ed, dr, fl);
            checks++; if (count !== exp_count) begin errors++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", i, count, exp_count); end
            checks++; if (full !== exp_full) begin errors++; $display("[TB] FAIL rand_full[%0d]: got %b expected %b", i, full, exp_full); end
            checks++; if (empty !== exp_empty) begin errors++; $display("[TB] FAIL rand_empty[%0d]: got %b expected %b", i, empty, exp_empty); end
            checks++; if (enq_ready !== exp_enq_ready) begin errors++; $display("[TB] FAIL rand_enq_ready[%0d]: got %b expected %b", i, enq_ready, exp_enq_ready); end
            checks++; if (deq_valid !== exp_deq_valid) begin errors++; $display("[TB] FAIL rand_deq_valid[%0d]: got %b expected %b", i, deq_valid, exp_deq_valid); end
            checks++; if (deq_data !== exp_deq_data) begin errors++; $display("[TB] FAIL rand_deq_data[%0d]: got %h expected %h", i, deq_data, exp_deq_data); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
